// File: rtl/fft_pkg.sv
// Shared definitions for the IFFT ping-pong sample buffer: default sizes,
// bank-count encoding and the write-address bit-reversal helper.
package fft_pkg;

    localparam int DW_DEF = 37;
    localparam int AW_DEF = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    // Reverses the low w bits of a; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[5'(i)] = a[5'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_mem_if.sv
// Producer/consumer bus of the ping-pong buffer. The master side is the
// FFT stage pair; the slave side is the buffer itself.
interface fft_pingpong_mem_if #(
    parameter int DW = 37,
    parameter int AW = 5
);
    logic          wr_en1;
    logic [AW-1:0] wr_addr1;
    logic [DW-1:0] wr_data1;
    logic          wr_en2;
    logic [AW-1:0] wr_addr2;
    logic [DW-1:0] wr_data2;
    logic          wr_bitrev;
    logic          wr_done;
    logic          wr_ready;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          rd_done;
    logic          rd_valid;
    logic          wr_collision;
    logic          err;

    modport master (
        output wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2,
               wr_bitrev, wr_done, rd_addr1, rd_addr2, rd_done,
        input  wr_ready, rd_data1, rd_data2, rd_valid, wr_collision, err
    );

    modport slave (
        input  wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2,
               wr_bitrev, wr_done, rd_addr1, rd_addr2, rd_done,
        output wr_ready, rd_data1, rd_data2, rd_valid, wr_collision, err
    );
endinterface

// File: rtl/fft_bank_ram.sv
// One sample bank: two write ports (port 2 wins on equal addresses) and two
// asynchronous read ports. Contents are deliberately not reset.
module fft_bank_ram #(
    parameter int DW = 37,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic          we2_i,
    input  logic [AW-1:0] waddr2_i,
    input  logic [DW-1:0] wdata2_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Port 2 is assigned last so its value sticks on an address clash.
    always_ff @(posedge clk) begin
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
        if (we2_i) mem_q[waddr2_i] <= wdata2_i;
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/fft_pingpong_mem.sv
// Two-bank ping-pong buffer between IFFT stages: bank handoff control,
// optional bit-reversed writes and combinational or registered reads.
//
//   cnt   | meaning
//   EMPTY | no full bank; consumer waits, rd_valid=0
//   ONE   | one full bank; producer fills the other in parallel
//   FULL  | both banks full; producer stalls, wr_ready=0
module fft_pingpong_mem
    import fft_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_REG = 0
) (
    input  logic               clk,
    input  logic               rst,
    fft_pingpong_mem_if.slave  bus
);

    cnt_e cnt_q, cnt_d;
    logic wr_sel_q, wr_sel_d;
    logic rd_sel_q, rd_sel_d;
    logic wr_collision_q, wr_collision_d;
    logic err_q, err_d;

    logic          wr_ready_w, rd_valid_w;
    logic          we1_w, we2_w;
    logic          wr_acc_w, rd_acc_w;
    logic [AW-1:0] waddr1_w, waddr2_w;
    logic [DW-1:0] b_rd1_w [2];
    logic [DW-1:0] b_rd2_w [2];
    logic [DW-1:0] rd_data1_d, rd_data2_d;

    assign wr_ready_w = (cnt_q != FULL);
    assign rd_valid_w = (cnt_q != EMPTY);

    assign waddr1_w = bus.wr_bitrev ? AW'(bitrev(32'(bus.wr_addr1), AW)) : bus.wr_addr1;
    assign waddr2_w = bus.wr_bitrev ? AW'(bitrev(32'(bus.wr_addr2), AW)) : bus.wr_addr2;

    assign we1_w    = bus.wr_en1  & wr_ready_w;
    assign we2_w    = bus.wr_en2  & wr_ready_w;
    assign wr_acc_w = bus.wr_done & wr_ready_w;
    assign rd_acc_w = bus.rd_done & rd_valid_w;

    always_comb begin
        cnt_d          = cnt_q;
        wr_sel_d       = wr_sel_q ^ wr_acc_w;
        rd_sel_d       = rd_sel_q ^ rd_acc_w;
        wr_collision_d = we1_w & we2_w & (waddr1_w == waddr2_w);
        err_d          = err_q
                       | (bus.wr_en1  & ~wr_ready_w)
                       | (bus.wr_en2  & ~wr_ready_w)
                       | (bus.wr_done & ~wr_ready_w)
                       | (bus.rd_done & ~rd_valid_w);
        // Simultaneous handoffs cancel out in the count.
        case ({wr_acc_w, rd_acc_w})
            2'b10:   cnt_d = (cnt_q == EMPTY) ? ONE : FULL;
            2'b01:   cnt_d = (cnt_q == FULL)  ? ONE : EMPTY;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= EMPTY;
            wr_sel_q       <= 1'b0;
            rd_sel_q       <= 1'b0;
            wr_collision_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            wr_sel_q       <= wr_sel_d;
            rd_sel_q       <= rd_sel_d;
            wr_collision_q <= wr_collision_d;
            err_q          <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_bank_ram #(.DW(DW), .AW(AW)) u_bank (
            .clk      (clk),
            .we1_i    (we1_w & (wr_sel_q == 1'(b))),
            .waddr1_i (waddr1_w),
            .wdata1_i (bus.wr_data1),
            .we2_i    (we2_w & (wr_sel_q == 1'(b))),
            .waddr2_i (waddr2_w),
            .wdata2_i (bus.wr_data2),
            .raddr1_i (bus.rd_addr1),
            .raddr2_i (bus.rd_addr2),
            .rdata1_o (b_rd1_w[b]),
            .rdata2_o (b_rd2_w[b])
        );
    end

    // Banks that were discarded (no full bank) read back as zero.
    assign rd_data1_d = rd_valid_w ? b_rd1_w[rd_sel_q] : '0;
    assign rd_data2_d = rd_valid_w ? b_rd2_w[rd_sel_q] : '0;

    if (RD_REG != 0) begin : g_rd_reg
        logic [DW-1:0] rd_data1_q, rd_data2_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data1_q <= '0;
                rd_data2_q <= '0;
            end else begin
                rd_data1_q <= rd_data1_d;
                rd_data2_q <= rd_data2_d;
            end
        end
        assign bus.rd_data1 = rd_data1_q;
        assign bus.rd_data2 = rd_data2_q;
    end else begin : g_rd_comb
        assign bus.rd_data1 = rd_data1_d;
        assign bus.rd_data2 = rd_data2_d;
    end

    assign bus.wr_ready     = wr_ready_w;
    assign bus.rd_valid     = rd_valid_w;
    assign bus.wr_collision = wr_collision_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_fft_pingpong_mem.sv
// Scoreboard bench for fft_pingpong_mem: one instance with combinational
// reads, one with registered reads; expectations are checked on negedge.
module tb_fft_pingpong_mem;

    localparam int DW = 37;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fft_pingpong_mem_if #(.DW(DW), .AW(AW)) bi0 ();
    fft_pingpong_mem_if #(.DW(DW), .AW(AW)) bi1 ();

    fft_pingpong_mem #(.DW(DW), .AW(AW), .RD_REG(0)) dut0 (.clk(clk), .rst(rst), .bus(bi0));
    fft_pingpong_mem #(.DW(DW), .AW(AW), .RD_REG(1)) dut1 (.clk(clk), .rst(rst), .bus(bi1));

    typedef enum int {S_RDY0, S_VAL0, S_ERR0, S_COL0, S_RD1_0, S_RD2_0,
                      S_RD1_1, S_VAL1, S_RDY1} sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [63:0] sample(input sig_e s);
        case (s)
            S_RDY0:  return 64'(bi0.wr_ready);
            S_VAL0:  return 64'(bi0.rd_valid);
            S_ERR0:  return 64'(bi0.err);
            S_COL0:  return 64'(bi0.wr_collision);
            S_RD1_0: return 64'(bi0.rd_data1);
            S_RD2_0: return 64'(bi0.rd_data2);
            S_RD1_1: return 64'(bi1.rd_data1);
            S_VAL1:  return 64'(bi1.rd_valid);
            S_RDY1:  return 64'(bi1.wr_ready);
            default: return '1;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // dly=0: checked at the negedge of the current cycle; dly=1: after the next edge.
    task automatic expect_at(input int dly, input sig_e s, input logic [63:0] v, input string nm);
        exp_t e;
        int   i;
        e.cyc  = cyc + dly;
        e.sig  = s;
        e.exp  = v;
        e.name = nm;
        i = sb_q.size();
        while (i > 0 && sb_q[i-1].cyc > e.cyc) i--;
        sb_q.insert(i, e);
    endtask

    initial forever begin
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, sample(e.sig), e.exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input bit d, input bit e1, input int a1, input int v1,
                          input bit e2, input int a2, input int v2, input bit rev);
        if (!d) begin
            bi0.wr_en1 = e1; bi0.wr_addr1 = AW'(a1); bi0.wr_data1 = DW'(v1);
            bi0.wr_en2 = e2; bi0.wr_addr2 = AW'(a2); bi0.wr_data2 = DW'(v2);
            bi0.wr_bitrev = rev;
        end else begin
            bi1.wr_en1 = e1; bi1.wr_addr1 = AW'(a1); bi1.wr_data1 = DW'(v1);
            bi1.wr_en2 = e2; bi1.wr_addr2 = AW'(a2); bi1.wr_data2 = DW'(v2);
            bi1.wr_bitrev = rev;
        end
    endtask

    task automatic set_ctl(input bit d, input bit wd, input bit rdn);
        if (!d) begin bi0.wr_done = wd; bi0.rd_done = rdn; end
        else    begin bi1.wr_done = wd; bi1.rd_done = rdn; end
    endtask

    task automatic set_rd(input bit d, input int a1, input int a2);
        if (!d) begin bi0.rd_addr1 = AW'(a1); bi0.rd_addr2 = AW'(a2); end
        else    begin bi1.rd_addr1 = AW'(a1); bi1.rd_addr2 = AW'(a2); end
    endtask

    // Writes data base+k to address k (or its reversal), two words per cycle.
    task automatic fill(input bit d, input int base, input bit rev);
        for (int i = 0; i < 16; i++) begin
            set_wr(d, 1'b1, 2*i, base + 2*i, 1'b1, 2*i + 1, base + 2*i + 1, rev);
            step();
        end
        set_wr(d, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic pulse_done(input bit d, input bit wd, input bit rdn);
        set_ctl(d, wd, rdn);
        step();
        set_ctl(d, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            set_wr(d[0], 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
            set_ctl(d[0], 1'b0, 1'b0);
            set_rd(d[0], 0, 0);
        end
        step();
        step();
        rst = 1'b0;
        expect_at(0, S_RDY0, 1, "rst_wr_ready");
        expect_at(0, S_VAL0, 0, "rst_rd_valid");
        expect_at(0, S_ERR0, 0, "rst_err");
        step();

        // bit-reversed fill of bank 0
        fill(1'b0, 0, 1'b1);
        pulse_done(1'b0, 1'b1, 1'b0);
        set_rd(1'b0, 1, 3);
        expect_at(0, S_VAL0, 1, "brev_rd_valid");
        expect_at(0, S_RD1_0, 16, "brev_rd1_a1");
        expect_at(0, S_RD2_0, 24, "brev_rd2_a3");
        expect_at(0, S_RDY0, 1, "brev_wr_ready");
        step();

        // drain to empty: reads gate to zero
        pulse_done(1'b0, 1'b0, 1'b1);
        expect_at(0, S_VAL0, 0, "empty_rd_valid");
        expect_at(0, S_RD1_0, 0, "empty_rd1_zero");
        step();

        // ping-pong overlap
        fill(1'b0, 'hA00, 1'b0);
        pulse_done(1'b0, 1'b1, 1'b0);
        fill(1'b0, 'hB00, 1'b0);
        pulse_done(1'b0, 1'b1, 1'b0);
        set_rd(1'b0, 4, 9);
        expect_at(0, S_RDY0, 0, "full_wr_ready");
        expect_at(0, S_VAL0, 1, "full_rd_valid");
        expect_at(0, S_RD1_0, 'hA04, "full_rd1_a");
        expect_at(0, S_RD2_0, 'hA09, "full_rd2_a");
        pulse_done(1'b0, 1'b0, 1'b1);
        expect_at(0, S_RD1_0, 'hB04, "pp_rd1_b");
        expect_at(0, S_RD2_0, 'hB09, "pp_rd2_b");
        expect_at(0, S_RDY0, 1, "pp_wr_ready");
        step();

        // simultaneous done, with a write in the done cycle landing in the old bank
        fill(1'b0, 'hC00, 1'b0);
        set_wr(1'b0, 1'b1, 0, 'hCCC, 1'b0, 0, 0, 1'b0);
        pulse_done(1'b0, 1'b1, 1'b1);
        set_wr(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        set_rd(1'b0, 0, 9);
        expect_at(0, S_RD1_0, 'hCCC, "sim_rd1_oldbank");
        expect_at(0, S_RD2_0, 'hC09, "sim_rd2_c");
        expect_at(0, S_VAL0, 1, "sim_rd_valid");
        expect_at(0, S_RDY0, 1, "sim_wr_ready");
        step();

        // collision on address 7
        set_wr(1'b0, 1'b1, 7, 'h11, 1'b1, 7, 'h22, 1'b0);
        expect_at(0, S_COL0, 0, "col_before");
        expect_at(1, S_COL0, 1, "col_pulse");
        step();
        set_wr(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        expect_at(0, S_ERR0, 0, "col_no_err");
        expect_at(1, S_COL0, 0, "col_one_cycle");
        pulse_done(1'b0, 1'b1, 1'b1);
        set_rd(1'b0, 7, 6);
        expect_at(0, S_RD1_0, 'h22, "col_port2_wins");
        expect_at(0, S_RD2_0, 'hB06, "col_neighbour");
        step();

        // write while full is dropped and flagged
        pulse_done(1'b0, 1'b1, 1'b0);
        set_wr(1'b0, 1'b1, 8, 'h3FF, 1'b0, 0, 0, 1'b0);
        expect_at(0, S_RDY0, 0, "err_full");
        expect_at(0, S_ERR0, 0, "err_before");
        step();
        set_wr(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        set_rd(1'b0, 8, 6);
        expect_at(0, S_ERR0, 1, "err_set");
        expect_at(0, S_RD1_0, 'hB08, "err_dropped");
        step();

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_wr_ready", 64'(bi0.wr_ready), 1);
        check("arst_rd_valid", 64'(bi0.rd_valid), 0);
        check("arst_err", 64'(bi0.err), 0);
        check("arst_rd_data1", 64'(bi0.rd_data1), 0);
        step();
        rst = 1'b0;

        // rd_done on empty
        set_ctl(1'b0, 1'b0, 1'b1);
        expect_at(0, S_ERR0, 0, "rdempty_before");
        step();
        set_ctl(1'b0, 1'b0, 1'b0);
        expect_at(0, S_ERR0, 1, "rdempty_err");
        expect_at(0, S_VAL0, 0, "rdempty_valid");
        step();

        // registered-read instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_rd(1'b1, 0, 0);
        expect_at(0, S_RD1_1, 0, "rr_rst_data");
        expect_at(0, S_VAL1, 0, "rr_rst_valid");
        step();
        fill(1'b1, 'h500, 1'b0);
        pulse_done(1'b1, 1'b1, 1'b0);
        expect_at(0, S_RD1_1, 0, "rr_lat_zero");
        expect_at(0, S_VAL1, 1, "rr_valid");
        expect_at(1, S_RD1_1, 'h500, "rr_addr0");
        fill(1'b1, 'h600, 1'b0);
        pulse_done(1'b1, 1'b1, 1'b0);
        set_rd(1'b1, 5, 0);
        expect_at(0, S_RDY1, 0, "rr_full");
        expect_at(0, S_RD1_1, 'h500, "rr_not_yet");
        expect_at(1, S_RD1_1, 'h505, "rr_addr5");
        step();
        set_rd(1'b1, 6, 0);
        set_ctl(1'b1, 1'b0, 1'b1);
        expect_at(1, S_RD1_1, 'h506, "rr_bank_at_edge");
        step();
        set_ctl(1'b1, 1'b0, 1'b0);
        expect_at(0, S_RDY1, 1, "rr_ready_after");
        expect_at(1, S_RD1_1, 'h606, "rr_next_bank");
        step();
        step();

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) step();
        if (sb_q.size() > 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_pingpong_mem.md
Name: fft_pingpong_mem

Overview:
Parametrised two-bank (ping-pong) sample buffer for the IFFT datapath. It generalises the single-bank 32-entry, 37-bit dual-read memories to configurable width and depth. It adds dual write ports with optional bit-reversed write addressing, producer/consumer bank handoff, and optional registered reads. Stage N writes one bank while stage N+1 reads the other.

Parameters:
DW, 37, data word width (complex sample, packed).
AW, 5, address width; each bank holds 2**AW words.
RD_REG, 0, read mode: 0 = combinational read, 1 = read data registered (1-cycle latency).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en1  in  1  write strobe, port 1.
wr_addr1  in  AW  write address, port 1.
wr_data1  in  DW  write data, port 1.
wr_en2  in  1  write strobe, port 2.
wr_addr2  in  AW  write address, port 2.
wr_data2  in  DW  write data, port 2.
wr_bitrev  in  1  1 = bit-reverse both write addresses before use.
wr_done  in  1  producer pulse: current write bank is complete.
wr_ready  out  1  a bank is free for writing.
rd_addr1  in  AW  read address, port 1.
rd_addr2  in  AW  read address, port 2.
rd_data1  out  DW  read data, port 1.
rd_data2  out  DW  read data, port 2.
rd_done  in  1  consumer pulse: current read bank is consumed.
rd_valid  out  1  a full bank is available for reading.
wr_collision  out  1  1-cycle pulse: both write ports hit the same address.
err  out  1  sticky protocol error flag.

Behaviour:
- State: wr_sel (bank being written), rd_sel (bank being read), cnt in 0..2 (full banks). Reset: wr_sel=0, rd_sel=0, cnt=0, wr_collision=0, err=0, registered read outputs=0. Memory contents are not reset.
- wr_ready = (cnt != 2). rd_valid = (cnt != 0). Both are combinational from state, so after reset wr_ready=1 and rd_valid=0.
- Writes: wr_enN with wr_ready writes bank wr_sel at the effective address. The effective address is wr_addrN, or its AW-bit reversal when wr_bitrev=1. Writes take effect at the clock edge.
- Both ports enabled with equal effective addresses: port 2 data is stored and wr_collision pulses for 1 cycle. This is not an error.
- Accepted wr_done (wr_done & wr_ready): wr_sel toggles and cnt increments.
- Accepted rd_done (rd_done & rd_valid): rd_sel toggles and cnt decrements.
- Both accepted in the same cycle: both selectors toggle and cnt is unchanged.
- Writes in the same cycle as an accepted wr_done go to the old bank.
- Reads address bank rd_sel.
  - RD_REG=0: rd_dataN = mem[rd_sel][rd_addrN] combinationally.
  - RD_REG=1: registered; data appears the cycle after the address, using the rd_sel value at the sampling edge.
  - When rd_valid=0, rd_dataN returns 0.
- Read/write bank conflict cannot occur in legal operation: rd_sel == wr_sel only when cnt is 0 or 2.
- err is set (sticky until rst) on any of:
  - wr_enN while wr_ready=0; the write is dropped.
  - wr_done while wr_ready=0; the pulse is ignored.
  - rd_done while rd_valid=0; the pulse is ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Buffered banks are logically discarded: rd_valid=0 even though memory still holds data.

Decomposition:
- Shared package (fft_pkg): DW/AW defaults, a bit-reverse function of width AW, and the bank-count encoding constants (EMPTY=0, ONE=1, FULL=2).
- One sub-module, fft_bank_ram: a single bank with 2 write ports (port 2 priority), 2 async read ports, no reset. It is instantiated twice. Handoff control, address reversal and read muxing/registering stay in the top level.

Test Plan:
- Reset/idle: assert rst mid-cycle → wr_ready=1, rd_valid=0, err=0, rd_data1=0 immediately, without waiting for a clock edge.
- Bit-reversed fill (AW=5, RD_REG=0):
  - Stimulus: write k=0..31 with data=k and wr_bitrev=1, two words per cycle, then pulse wr_done.
  - Response: rd_valid=1, and rd_addr1=1 returns 16 (address 1 reversed is 16); rd_addr2=3 returns 24.
- Ping-pong overlap:
  - Stimulus: fill bank0 with 0xA.., pulse wr_done; fill bank1 with 0xB.., pulse wr_done.
  - Response after second wr_done: wr_ready=0, cnt=2, reads return the 0xA.. pattern.
  - Stimulus: rd_done → Response: reads return 0xB.., wr_ready=1.
- Simultaneous done:
  - Stimulus: with cnt=1, pulse wr_done and rd_done in the same cycle.
  - Response: cnt stays 1, both selectors toggle, and reads now return the newly written bank.
- Collision and errors:
  - Stimulus: wr_en1=wr_en2=1, addr 7, data1=0x11, data2=0x22 → Response: wr_collision=1 for 1 cycle, mem[7]=0x22, err=0.
  - Stimulus: a write with cnt=2 → Response: err=1 and data is not stored.
  - Stimulus: rd_done with cnt=0 → Response: err stays 1.
- Registered read (RD_REG=1):
  - Stimulus: present rd_addr1=5 at edge t.
  - Response: rd_data1=mem[5] after edge t+1, never at t.
  - Stimulus: rd_done at edge t alongside that read → Response: the data comes from the bank selected at edge t.
